// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the ARM-style data-processing executor.
//   - state_t   : four-phase executor sequence (wait / read / execute / writeback)
//   - opcode_t  : the sixteen data-processing opcodes, encoded as in IR[24:21]
//   - shift_t   : barrel shifter operation, encoded as in IR[6:5]
//   - localparams naming every instruction field bit position
//   - cond_pass : condition-code evaluation against NZCV, used only when
//                 COND_EXEC_EN is defined
//   - is_test_op: opcodes that only set flags and never write a register
// ---------------------------------------------------------------------------
package cpu_pkg;

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_t;

   typedef enum logic [3:0] {
      OP_AND = 4'h0,
      OP_EOR = 4'h1,
      OP_SUB = 4'h2,
      OP_RSB = 4'h3,
      OP_ADD = 4'h4,
      OP_ADC = 4'h5,
      OP_SBC = 4'h6,
      OP_RSC = 4'h7,
      OP_TST = 4'h8,
      OP_TEQ = 4'h9,
      OP_CMP = 4'hA,
      OP_CMN = 4'hB,
      OP_ORR = 4'hC,
      OP_MOV = 4'hD,
      OP_BIC = 4'hE,
      OP_MVN = 4'hF
   } opcode_t;

   typedef enum logic [1:0] {
      SH_LSL = 2'd0,
      SH_LSR = 2'd1,
      SH_ASR = 2'd2,
      SH_ROR = 2'd3
   } shift_t;

   // Instruction field positions
   localparam int COND_MSB   = 31;
   localparam int COND_LSB   = 28;
   localparam int CLASS_MSB  = 27;
   localparam int CLASS_LSB  = 26;
   localparam int IMM_BIT    = 25;
   localparam int OP_MSB     = 24;
   localparam int OP_LSB     = 21;
   localparam int S_BIT      = 20;
   localparam int RN_MSB     = 19;
   localparam int RN_LSB     = 16;
   localparam int RD_MSB     = 15;
   localparam int RD_LSB     = 12;
   localparam int RS_MSB     = 11;
   localparam int RS_LSB     = 8;
   localparam int SHIMM_MSB  = 11;
   localparam int SHIMM_LSB  = 7;
   localparam int SHTYPE_MSB = 6;
   localparam int SHTYPE_LSB = 5;
   localparam int SHREG_BIT  = 4;
   localparam int RM_MSB     = 3;
   localparam int RM_LSB     = 0;
   localparam int IMM8_MSB   = 7;
   localparam int IMM8_LSB   = 0;

   // nzcv is ordered {N,Z,C,V}; NV (4'hF) never passes
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      n = nzcv[3];
      z = nzcv[2];
      c = nzcv[1];
      v = nzcv[0];
      case (cond)
         4'h0:    return z;
         4'h1:    return !z;
         4'h2:    return c;
         4'h3:    return !c;
         4'h4:    return n;
         4'h5:    return !n;
         4'h6:    return v;
         4'h7:    return !v;
         4'h8:    return c && !z;
         4'h9:    return !c || z;
         4'hA:    return n == v;
         4'hB:    return n != v;
         4'hC:    return !z && (n == v);
         4'hD:    return z || (n != v);
         4'hE:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_test_op(input opcode_t op);
      return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// ---------------------------------------------------------------------------
// cpu_alu
// Combinational barrel shifter followed by the 32-bit data-processing ALU.
// Ports:
//   a          in  32  first operand (Rn)
//   b          in  32  second operand before shifting (Rm, or zero-extended imm8)
//   shift_amt  in  8   shift/rotate amount (already doubled for immediates)
//   shift_type in  2   LSL/LSR/ASR/ROR, ignored when imm is set
//   imm        in  1   immediate operand: b is rotated right by shift_amt
//   opcode     in  4   data-processing opcode
//   c_in       in  1   current C flag (ADC/SBC/RSC input, zero-shift carry)
//   v_in       in  1   current V flag (kept by logical ops)
//   result     out 32  ALU result
//   n,z,c,v    out 1   candidate flags for this result
// ---------------------------------------------------------------------------
module cpu_alu
   import cpu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [7:0]  shift_amt,
   input  logic [1:0]  shift_type,
   input  logic        imm,
   input  logic [3:0]  opcode,
   input  logic        c_in,
   input  logic        v_in,
   output logic [31:0] result,
   output logic        n,
   output logic        z,
   output logic        c,
   output logic        v
);

   shift_t      sh_type;
   logic [4:0]  amt5;
   logic [4:0]  idx;
   logic [31:0] op2;
   logic        sh_c;
   opcode_t     op;
   logic [31:0] x;
   logic [31:0] y;
   logic        ci;
   logic        arith;
   logic [32:0] sum;

   // Barrel shifter. A zero amount passes the operand through and keeps the
   // old carry; register-specified amounts of 32 and above saturate.
   always_comb begin
      sh_type = imm ? SH_ROR : shift_t'(shift_type);
      amt5    = shift_amt[4:0];
      idx     = 5'd0;
      op2     = b;
      sh_c    = c_in;
      if (shift_amt != 8'd0) begin
         case (sh_type)
            SH_LSL: begin
               if (shift_amt < 8'd32) begin
                  op2  = b << amt5;
                  idx  = 5'd0 - amt5;
                  sh_c = b[idx];
               end else if (shift_amt == 8'd32) begin
                  op2  = '0;
                  sh_c = b[0];
               end else begin
                  op2  = '0;
                  sh_c = 1'b0;
               end
            end
            SH_LSR: begin
               if (shift_amt < 8'd32) begin
                  op2  = b >> amt5;
                  idx  = amt5 - 5'd1;
                  sh_c = b[idx];
               end else if (shift_amt == 8'd32) begin
                  op2  = '0;
                  sh_c = b[31];
               end else begin
                  op2  = '0;
                  sh_c = 1'b0;
               end
            end
            SH_ASR: begin
               if (shift_amt < 8'd32) begin
                  op2  = $unsigned($signed(b) >>> amt5);
                  idx  = amt5 - 5'd1;
                  sh_c = b[idx];
               end else begin
                  op2  = {32{b[31]}};
                  sh_c = b[31];
               end
            end
            default: begin
               // Rotating by a non-zero multiple of 32 leaves b intact but
               // still reports bit 31 as the carry.
               op2  = (b >> amt5) | (b << (5'd0 - amt5));
               sh_c = op2[31];
            end
         endcase
      end
   end

   // ALU. Every arithmetic op is folded into x + y + ci so that carry and
   // overflow come out of one adder; subtraction inverts the subtrahend.
   always_comb begin
      op     = opcode_t'(opcode);
      x      = a;
      y      = op2;
      ci     = 1'b0;
      arith  = 1'b1;
      result = '0;
      case (op)
         OP_SUB, OP_CMP: begin
            y  = ~op2;
            ci = 1'b1;
         end
         OP_RSB: begin
            x  = op2;
            y  = ~a;
            ci = 1'b1;
         end
         OP_ADD, OP_CMN: ci = 1'b0;
         OP_ADC: ci = c_in;
         OP_SBC: begin
            y  = ~op2;
            ci = c_in;
         end
         OP_RSC: begin
            x  = op2;
            y  = ~a;
            ci = c_in;
         end
         default: arith = 1'b0;
      endcase

      sum = {1'b0, x} + {1'b0, y} + {32'b0, ci};

      case (op)
         OP_AND, OP_TST: result = a & op2;
         OP_EOR, OP_TEQ: result = a ^ op2;
         OP_ORR:         result = a | op2;
         OP_MOV:         result = op2;
         OP_BIC:         result = a & ~op2;
         OP_MVN:         result = ~op2;
         default:        result = sum[31:0];
      endcase

      n = result[31];
      z = (result == 32'd0);
      c = arith ? sum[32] : sh_c;
      v = arith ? ((x[31] == y[31]) && (sum[31] != x[31])) : v_in;
   end

endmodule

// File: rtl/cpu.sv
// ---------------------------------------------------------------------------
// cpu
// Multi-cycle executor for ARM-style 32-bit data-processing instructions.
// Each instruction takes four clocks: WAIT (latch instr) -> READ (fetch
// operands) -> EXEC (shift + ALU, result to datapath_out) -> WB (register
// and flag writeback). Holds a 16x32 register file, which is not reset.
// Ports:
//   clk           in  1   rising-edge clock
//   rst_n         in  1   synchronous active-low reset
//   instr         in  32  instruction word, sampled while waiting is high
//   waiting       out 1   idle in WAIT and accepting instr this cycle
//   status_out    out 32  {N,Z,C,V,28'b0}
//   datapath_out  out 32  result of the most recent executed instruction
// Build option:
//   COND_EXEC_EN  when defined, IR[31:28] is checked against NZCV and a
//                 failing instruction behaves like a NOP; otherwise every
//                 instruction executes.
// ---------------------------------------------------------------------------
module cpu
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   output logic        waiting,
   output logic [31:0] status_out,
   output logic [31:0] datapath_out
);

   state_t      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [7:0]  s_q, s_d;
   logic [31:0] dp_q, dp_d;
   logic [3:0]  flags_q, flags_d;
   logic [3:0]  cand_q, cand_d;
   logic        exec_ok_q, exec_ok_d;
   logic [31:0] regs_q [16];
   logic [31:0] regs_d [16];

   logic [3:0]  rn, rm, rs, rd;
   opcode_t     op;
   logic        imm_sel;
   logic [31:0] alu_b;
   logic [7:0]  alu_amt;
   logic [31:0] alu_res;
   logic        alu_n, alu_z, alu_c, alu_v;
   logic        cond_ok;
   logic        exec_en;

   assign rn      = ir_q[RN_MSB:RN_LSB];
   assign rm      = ir_q[RM_MSB:RM_LSB];
   assign rs      = ir_q[RS_MSB:RS_LSB];
   assign rd      = ir_q[RD_MSB:RD_LSB];
   assign op      = opcode_t'(ir_q[OP_MSB:OP_LSB]);
   assign imm_sel = ir_q[IMM_BIT];

   // Immediate operands rotate imm8 right by twice the 4-bit rotate field;
   // register operands shift by either the imm5 field or the low byte of Rs.
   assign alu_b   = imm_sel ? {24'b0, ir_q[IMM8_MSB:IMM8_LSB]} : b_q;
   assign alu_amt = imm_sel ? {3'b0, ir_q[RS_MSB:RS_LSB], 1'b0}
                  : (ir_q[SHREG_BIT] ? s_q : {3'b0, ir_q[SHIMM_MSB:SHIMM_LSB]});

`ifdef COND_EXEC_EN
   assign cond_ok = cond_pass(ir_q[COND_MSB:COND_LSB], flags_q);
`else
   logic cond_unused;
   assign cond_unused = ^ir_q[COND_MSB:COND_LSB];
   assign cond_ok     = 1'b1;
`endif

   // Only the data-processing class executes; other classes are 4-cycle NOPs
   assign exec_en = (ir_q[CLASS_MSB:CLASS_LSB] == 2'b00) && cond_ok;

   cpu_alu u_alu (
      .a          (a_q),
      .b          (alu_b),
      .shift_amt  (alu_amt),
      .shift_type (ir_q[SHTYPE_MSB:SHTYPE_LSB]),
      .imm        (imm_sel),
      .opcode     (ir_q[OP_MSB:OP_LSB]),
      .c_in       (flags_q[1]),
      .v_in       (flags_q[0]),
      .result     (alu_res),
      .n          (alu_n),
      .z          (alu_z),
      .c          (alu_c),
      .v          (alu_v)
   );

   // State register; reset always returns to WAIT, aborting any instruction
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_WAIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a fixed four-step ring, one step per clock
   always_comb begin
      state_d = S_WAIT;
      case (state_q)
         S_WAIT:  state_d = S_READ;
         S_READ:  state_d = S_EXEC;
         S_EXEC:  state_d = S_WB;
         default: state_d = S_WAIT;
      endcase
   end

   // FSM outputs
   always_comb begin
      waiting = (state_q == S_WAIT);
   end

   // Datapath next-state: each phase loads only its own registers
   always_comb begin
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      s_d       = s_q;
      dp_d      = dp_q;
      flags_d   = flags_q;
      cand_d    = cand_q;
      exec_ok_d = exec_ok_q;
      regs_d    = regs_q;
      case (state_q)
         S_WAIT: begin
            ir_d = instr;
         end
         S_READ: begin
            a_d = regs_q[rn];
            b_d = regs_q[rm];
            s_d = regs_q[rs][7:0];
         end
         S_EXEC: begin
            exec_ok_d = exec_en;
            if (exec_en) begin
               dp_d   = alu_res;
               cand_d = {alu_n, alu_z, alu_c, alu_v};
            end
         end
         default: begin
            if (exec_ok_q && !is_test_op(op)) begin
               regs_d[rd] = dp_q;
            end
            if (exec_ok_q && ir_q[S_BIT]) begin
               flags_d = cand_q;
            end
         end
      endcase
   end

   // Datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         s_q       <= '0;
         dp_q      <= '0;
         flags_q   <= '0;
         cand_q    <= '0;
         exec_ok_q <= 1'b0;
      end else begin
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         s_q       <= s_d;
         dp_q      <= dp_d;
         flags_q   <= flags_d;
         cand_q    <= cand_d;
         exec_ok_q <= exec_ok_d;
      end
   end

   // Register file keeps its contents through reset, but a reset edge must
   // still suppress an in-flight writeback
   always_ff @(posedge clk) begin
      if (rst_n) begin
         regs_q <= regs_d;
      end
   end

   assign status_out   = {flags_q, 28'b0};
   assign datapath_out = dp_q;

endmodule

// File: tb/tb_cpu.sv
// ---------------------------------------------------------------------------
// tb_cpu
// Self-checking bench for cpu: directed program with literal expectations,
// a reset-during-execute case, then randomized instructions checked against
// an instruction-level model of the register file and flags.
// ---------------------------------------------------------------------------
module tb_cpu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'h0C00_0000;
   logic        waiting;
   logic [31:0] status_out;
   logic [31:0] datapath_out;

   cpu dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr        (instr),
      .waiting      (waiting),
      .status_out   (status_out),
      .datapath_out (datapath_out)
   );

   always #5 clk = ~clk;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   int          checks = 0;
   int          passes = 0;
   logic        checking = 1'b0;
   logic        exp_waiting = 1'b1;
   logic [31:0] exp_dp = 32'd0;
   logic [31:0] exp_status = 32'd0;

   // Architectural model state
   logic [31:0] mreg [16];
   logic [3:0]  mflags = 4'd0;
   logic [31:0] mdp = 32'd0;

   // One comparison; every check in the bench goes through here
   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act === expv) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
      end
   endtask

   // Compare the DUT against the model's expected outputs for this cycle
   task automatic checkOutput();
      check32("waiting", {31'b0, waiting}, {31'b0, exp_waiting});
      check32("datapath_out", datapath_out, exp_dp);
      check32("status_out", status_out, exp_status);
   endtask

   always @(negedge clk) begin
      if (checking) checkOutput();
   end

   function automatic logic condPass(input logic [3:0] cond);
`ifdef COND_EXEC_EN
      logic n, z, c, v;
      {n, z, c, v} = mflags;
      case (cond)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return c;
         4'h3: return !c;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return c && !z;
         4'h9: return !c || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
`else
      return (cond == cond) || 1'b1;
`endif
   endfunction

   // Instruction-level effect of one instruction on the architectural state
   task automatic modelStep(input logic [31:0] ins);
      logic [31:0] a, b, op2, res;
      logic [63:0] t;
      logic [1:0]  typ;
      logic [3:0]  op;
      logic        shc, c, v, arith;
      int          n;
      longint      ua, ub, sa, sb, ures, sres, cin, bor;
      if (ins[27:26] != 2'b00) return;
      if (!condPass(ins[31:28])) return;
      a   = mreg[ins[19:16]];
      shc = mflags[1];
      if (ins[25]) begin
         b   = {24'b0, ins[7:0]};
         n   = 2 * int'(ins[11:8]);
         typ = 2'b11;
      end else begin
         b   = mreg[ins[3:0]];
         n   = ins[4] ? int'(mreg[ins[11:8]][7:0]) : int'(ins[11:7]);
         typ = ins[6:5];
      end
      op2 = b;
      if (n != 0) begin
         case (typ)
            2'b00: begin t = {32'b0, b} << n; op2 = t[31:0]; shc = t[32]; end
            2'b01: begin t = {b, 32'b0} >> n; op2 = t[63:32]; shc = t[31]; end
            2'b10: begin t = $signed({b, 32'b0}) >>> n; op2 = t[63:32]; shc = t[31]; end
            default: begin t = {b, b} >> (n % 32); op2 = t[31:0]; shc = op2[31]; end
         endcase
      end
      ua  = a;
      ub  = op2;
      sa  = $signed(a);
      sb  = $signed(op2);
      cin = mflags[1];
      bor = 1 - cin;
      op  = ins[24:21];
      arith = 1'b1;
      c = 1'b0;
      ures = 0;
      sres = 0;
      res = 32'd0;
      case (op)
         4'h0, 4'h8: begin res = a & op2;  arith = 1'b0; end
         4'h1, 4'h9: begin res = a ^ op2;  arith = 1'b0; end
         4'hC:       begin res = a | op2;  arith = 1'b0; end
         4'hD:       begin res = op2;      arith = 1'b0; end
         4'hE:       begin res = a & ~op2; arith = 1'b0; end
         4'hF:       begin res = ~op2;     arith = 1'b0; end
         4'h4, 4'hB: begin ures = ua + ub; sres = sa + sb; c = ures > 64'hFFFF_FFFF; end
         4'h5:       begin ures = ua + ub + cin; sres = sa + sb + cin; c = ures > 64'hFFFF_FFFF; end
         4'h2, 4'hA: begin ures = ua - ub; sres = sa - sb; c = ua >= ub; end
         4'h6:       begin ures = ua - ub - bor; sres = sa - sb - bor; c = ua >= ub + bor; end
         4'h3:       begin ures = ub - ua; sres = sb - sa; c = ub >= ua; end
         default:    begin ures = ub - ua - bor; sres = sb - sa - bor; c = ub >= ua + bor; end
      endcase
      if (arith) res = 32'(ures);
      v = (sres > SMAX) || (sres < SMIN);
      mdp = res;
      if (ins[20]) begin
         mflags = {res[31], res == 32'd0, arith ? c : shc, arith ? v : mflags[0]};
      end
      if (op < 4'h8 || op > 4'hB) mreg[ins[15:12]] = res;
   endtask

   // Present one instruction and step the expected outputs cycle by cycle
   task automatic applyStimulus(input logic [31:0] ins);
      int guard;
      guard = 0;
      while (!waiting && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!waiting) begin
         checks++;
         $display("[TB] FAIL ready_timeout: waiting=0 after 20 cycles, required 1");
      end
      instr = ins;
      modelStep(ins);
      @(posedge clk); #1;
      exp_waiting = 1'b0;
      instr = 32'h0C00_0000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_dp = mdp;
      @(posedge clk); #1;
      exp_status  = {mflags, 28'b0};
      exp_waiting = 1'b1;
   endtask

   // Literal expectation on both the DUT and the model
   task automatic checkLiteral(input string name, input logic [31:0] dpv, input logic [31:0] stv);
      check32({name, "_dp"}, datapath_out, dpv);
      check32({name, "_status"}, status_out, stv);
      check32({name, "_model_dp"}, exp_dp, dpv);
      check32({name, "_model_status"}, exp_status, stv);
   endtask

   initial begin
      logic [31:0] ins;
      for (int i = 0; i < 16; i++) mreg[i] = 32'd0;

      rst_n = 1'b0;
      @(posedge clk); #1;
      checking = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check32("reset_waiting", {31'b0, waiting}, 32'd1);

      for (int k = 0; k < 16; k++) applyStimulus(32'hE3A0_0001 + k * 32'h1001);
      checkLiteral("setup_r15", 32'd16, 32'd0);

      applyStimulus(32'h0090_0000);
      checkLiteral("adds_r0", 32'd2, 32'd0);
      applyStimulus(32'hE081_1000);
      checkLiteral("add_r1_reg", 32'd4, 32'd0);
      applyStimulus(32'hE281_1008);
      checkLiteral("add_r1_imm", 32'd12, 32'd0);
      applyStimulus(32'hE082_2210);
      checkLiteral("add_lsl_rs", 32'd19, 32'd0);
      applyStimulus(32'hE090_0001);
      checkLiteral("adds_r0_r1", 32'd14, 32'd0);
      applyStimulus(32'hE053_3003);
      checkLiteral("subs_zero", 32'd0, 32'h6000_0000);
      applyStimulus(32'hE3E0_4102);
      checkLiteral("mvn_rot_imm", 32'h7FFF_FFFF, 32'h6000_0000);
      applyStimulus(32'hE294_4001);
      checkLiteral("adds_overflow", 32'h8000_0000, 32'h9000_0000);
      applyStimulus(32'h0C00_0000);
      checkLiteral("nop_class", 32'h8000_0000, 32'h9000_0000);

      // Reset while ADD R5,R5,#1 sits in EXEC: R5 must keep its value 6
      instr = 32'hE285_5001;
      @(posedge clk); #1;
      exp_waiting = 1'b0;
      instr = 32'h0C00_0000;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      mdp = 32'd0;
      mflags = 4'd0;
      exp_dp = 32'd0;
      exp_status = 32'd0;
      exp_waiting = 1'b1;
      check32("abort_waiting", {31'b0, waiting}, 32'd1);
      applyStimulus(32'hE1A0_6005);
      checkLiteral("abort_r5_kept", 32'd6, 32'd0);

      for (int i = 0; i < 300; i++) begin
         ins = $urandom();
         if ($urandom_range(7) != 0) ins[27:26] = 2'b00;
         applyStimulus(ins);
      end

      checking = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
